// File: rtl/ula_8_bits_controller.sv
// ---------------------------------------------------------------------------
// ula_8_bits_controller
//
// Command front-end for the 8-bit ULA. A command (opcode, operands, operand
// selectors) is accepted over a valid/ready handshake, the ULA inputs are
// driven from registers and held for SETTLE_CYCLES, then the ULA result and
// carry are captured and returned over a second valid/ready handshake.
// An 8-bit accumulator and a carry flag allow chained and multi-byte work.
//
// Parameters
//   SETTLE_CYCLES  ULA settle time before S/COUT are sampled (1..15)
//
// Ports
//   CLK, RST                 clock, asynchronous active-high reset
//   CMD_VALID / CMD_READY    command handshake (ready only in IDLE)
//   CMD_OP[2:0]              000 add, 001 sub, 010 and, 011 or, 100 not A
//   CMD_A, CMD_B             operands
//   CMD_USE_ACC              replace operand A with the accumulator
//   CMD_USE_CARRY            drive ULA_CIN from the stored carry flag
//   RSP_VALID / RSP_READY    response handshake
//   RSP_DATA, RSP_COUT       captured result and carry (carry 0 for logic ops)
//   RSP_ZERO, RSP_ERR        result-is-zero, illegal opcode
//   ACC                      accumulator (observation)
//   ULA_A, ULA_B, ULA_X,
//   ULA_CIN                  registered ULA drive
//   ULA_S, ULA_COUT          ULA result
//
//   state  | meaning
//   IDLE   | waiting for a command, CMD_READY=1
//   ISSUE  | ULA inputs held, settle counter running
//   RESP   | response presented until RSP_READY
// ---------------------------------------------------------------------------
module ula_8_bits_controller #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [2:0] CMD_OP,
  input  logic [7:0] CMD_A,
  input  logic [7:0] CMD_B,
  input  logic       CMD_USE_ACC,
  input  logic       CMD_USE_CARRY,
  output logic       RSP_VALID,
  input  logic       RSP_READY,
  output logic [7:0] RSP_DATA,
  output logic       RSP_COUT,
  output logic       RSP_ZERO,
  output logic       RSP_ERR,
  output logic [7:0] ACC,
  output logic       ULA_CIN,
  output logic [7:0] ULA_A,
  output logic [7:0] ULA_B,
  output logic [2:0] ULA_X,
  input  logic [7:0] ULA_S,
  input  logic       ULA_COUT
);

  // Out-of-range settle values are clamped so the counter never starts at
  // zero (which would wrap) or overflows its 4-bit width.
  localparam logic [3:0] SETTLE_LOAD =
    (SETTLE_CYCLES == 0)  ? 4'd1  :
    (SETTLE_CYCLES > 15)  ? 4'd15 :
                            4'(SETTLE_CYCLES);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] acc_q, acc_d;
  logic       carry_q, carry_d;
  logic [7:0] ula_a_q, ula_a_d;
  logic [7:0] ula_b_q, ula_b_d;
  logic [2:0] ula_x_q, ula_x_d;
  logic       ula_cin_q, ula_cin_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_cout_q, rsp_cout_d;
  logic       rsp_zero_q, rsp_zero_d;
  logic       rsp_err_q, rsp_err_d;

  logic       op_legal;
  logic       op_arith;
  logic       settle_done;

  assign op_legal    = (CMD_OP <= OP_NOT);
  // Carry is meaningful only for add/sub; decided from the held opcode so
  // the capture does not depend on CMD_* after acceptance.
  assign op_arith    = (ula_x_q == OP_ADD) || (ula_x_q == OP_SUB);
  assign settle_done = (cnt_q == 4'd1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    carry_d    = carry_q;
    ula_a_d    = ula_a_q;
    ula_b_d    = ula_b_q;
    ula_x_d    = ula_x_q;
    ula_cin_d  = ula_cin_q;
    rsp_data_d = rsp_data_q;
    rsp_cout_d = rsp_cout_q;
    rsp_zero_d = rsp_zero_q;
    rsp_err_d  = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          if (op_legal) begin
            ula_a_d   = CMD_USE_ACC ? acc_q : CMD_A;
            ula_b_d   = CMD_B;
            ula_x_d   = CMD_OP;
            ula_cin_d = CMD_USE_CARRY & carry_q;
            cnt_d     = SETTLE_LOAD;
            state_d   = ST_ISSUE;
          end else begin
            // Illegal op answers immediately and leaves ULA drive,
            // accumulator and carry untouched.
            rsp_data_d = 8'h00;
            rsp_cout_d = 1'b0;
            rsp_zero_d = 1'b1;
            rsp_err_d  = 1'b1;
            state_d    = ST_RESP;
          end
        end
      end

      ST_ISSUE: begin
        if (settle_done) begin
          cnt_d      = 4'd0;
          rsp_data_d = ULA_S;
          rsp_zero_d = (ULA_S == 8'h00);
          rsp_err_d  = 1'b0;
          rsp_cout_d = op_arith & ULA_COUT;
          carry_d    = op_arith & ULA_COUT;
          acc_d      = ULA_S;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_RESP: begin
        if (RSP_READY) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      acc_q      <= 8'h00;
      carry_q    <= 1'b0;
      ula_a_q    <= 8'h00;
      ula_b_q    <= 8'h00;
      ula_x_q    <= 3'b000;
      ula_cin_q  <= 1'b0;
      rsp_data_q <= 8'h00;
      rsp_cout_q <= 1'b0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      ula_a_q    <= ula_a_d;
      ula_b_q    <= ula_b_d;
      ula_x_q    <= ula_x_d;
      ula_cin_q  <= ula_cin_d;
      rsp_data_q <= rsp_data_d;
      rsp_cout_q <= rsp_cout_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign CMD_READY = (state_q == ST_IDLE);
  assign RSP_VALID = (state_q == ST_RESP);
  assign RSP_DATA  = rsp_data_q;
  assign RSP_COUT  = rsp_cout_q;
  assign RSP_ZERO  = rsp_zero_q;
  assign RSP_ERR   = rsp_err_q;
  assign ACC       = acc_q;
  assign ULA_A     = ula_a_q;
  assign ULA_B     = ula_b_q;
  assign ULA_X     = ula_x_q;
  assign ULA_CIN   = ula_cin_q;

endmodule

// File: tb/tb_ula_8_bits_controller.sv
// Bench for ula_8_bits_controller. The ULA is stood in for by a behavioural
// model; for logic ops it returns COUT=1 so the controller's forcing of the
// response carry to 0 is visible.
module tb_ula_8_bits_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance, SETTLE_CYCLES = 1
  logic       rst, cmd_valid, cmd_ready, cmd_use_acc, cmd_use_carry;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a, cmd_b;
  logic       rsp_valid, rsp_ready, rsp_cout, rsp_zero, rsp_err;
  logic [7:0] rsp_data, acc;
  logic       ula_cin, ula_cout;
  logic [7:0] ula_a, ula_b, ula_s;
  logic [2:0] ula_x;

  // second instance, SETTLE_CYCLES = 4
  logic       rst_4, cmd_valid_4, cmd_ready_4, cmd_use_acc_4, cmd_use_carry_4;
  logic [2:0] cmd_op_4;
  logic [7:0] cmd_a_4, cmd_b_4;
  logic       rsp_valid_4, rsp_ready_4, rsp_cout_4, rsp_zero_4, rsp_err_4;
  logic [7:0] rsp_data_4, acc_4;
  logic       ula_cin_4, ula_cout_4;
  logic [7:0] ula_a_4, ula_b_4, ula_s_4;
  logic [2:0] ula_x_4;

  function automatic logic [8:0] ula_model(input logic [2:0] x, input logic [7:0] a,
                                            input logic [7:0] b, input logic cin);
    logic [8:0] r;
    case (x)
      3'd0:    r = {1'b0, a} + {1'b0, b} + {8'd0, cin};
      3'd1:    r = {1'b0, a} - {1'b0, b} - {8'd0, cin};
      3'd2:    r = {1'b1, a & b};
      3'd3:    r = {1'b1, a | b};
      3'd4:    r = {1'b1, ~a};
      default: r = 9'h1EE;
    endcase
    return r;
  endfunction

  assign {ula_cout, ula_s}     = ula_model(ula_x, ula_a, ula_b, ula_cin);
  assign {ula_cout_4, ula_s_4} = ula_model(ula_x_4, ula_a_4, ula_b_4, ula_cin_4);

  ula_8_bits_controller #(.SETTLE_CYCLES(1)) dut (
    .CLK(clk), .RST(rst),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_OP(cmd_op),
    .CMD_A(cmd_a), .CMD_B(cmd_b), .CMD_USE_ACC(cmd_use_acc), .CMD_USE_CARRY(cmd_use_carry),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_DATA(rsp_data),
    .RSP_COUT(rsp_cout), .RSP_ZERO(rsp_zero), .RSP_ERR(rsp_err), .ACC(acc),
    .ULA_CIN(ula_cin), .ULA_A(ula_a), .ULA_B(ula_b), .ULA_X(ula_x),
    .ULA_S(ula_s), .ULA_COUT(ula_cout)
  );

  ula_8_bits_controller #(.SETTLE_CYCLES(4)) dut_4 (
    .CLK(clk), .RST(rst_4),
    .CMD_VALID(cmd_valid_4), .CMD_READY(cmd_ready_4), .CMD_OP(cmd_op_4),
    .CMD_A(cmd_a_4), .CMD_B(cmd_b_4), .CMD_USE_ACC(cmd_use_acc_4), .CMD_USE_CARRY(cmd_use_carry_4),
    .RSP_VALID(rsp_valid_4), .RSP_READY(rsp_ready_4), .RSP_DATA(rsp_data_4),
    .RSP_COUT(rsp_cout_4), .RSP_ZERO(rsp_zero_4), .RSP_ERR(rsp_err_4), .ACC(acc_4),
    .ULA_CIN(ula_cin_4), .ULA_A(ula_a_4), .ULA_B(ula_b_4), .ULA_X(ula_x_4),
    .ULA_S(ula_s_4), .ULA_COUT(ula_cout_4)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Caller is at a negedge; returns at the negedge after the accept edge.
  task automatic send_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic ua, input logic uc);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", 0, 1);
    cmd_valid     = 1'b1;
    cmd_op        = op;
    cmd_a         = a;
    cmd_b         = b;
    cmd_use_acc   = ua;
    cmd_use_carry = uc;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Counts accept-relative edges until RSP_VALID is seen.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) check("rsp_timeout", 0, 1);
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       ua;
    logic       uc;
    logic [7:0] e_data;
    logic       e_cout;
    logic       e_zero;
    logic       e_err;
    logic [7:0] e_acc;
    logic [2:0] e_x;
    logic       e_cin;
    int         e_lat;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    int lat;
    logic seen;
    logic [7:0] m_acc, a_eff, e_data;
    logic m_carry, cin, e_cout, e_err, ua, uc;
    logic [2:0] op;
    logic [7:0] a, b;
    int t;

    //           op    a      b     ua    uc    data   cout  zero  err   acc    x     cin  lat
    vecs[0]  = '{3'd1, 8'h83, 8'h01, 1'b0, 1'b0, 8'h82, 1'b0, 1'b0, 1'b0, 8'h82, 3'd1, 1'b0, 1};
    vecs[1]  = '{3'd0, 8'h83, 8'h01, 1'b0, 1'b0, 8'h84, 1'b0, 1'b0, 1'b0, 8'h84, 3'd0, 1'b0, 1};
    vecs[2]  = '{3'd2, 8'hFF, 8'h0F, 1'b1, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0, 8'h04, 3'd2, 1'b0, 1};
    vecs[3]  = '{3'd4, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFB, 1'b0, 1'b0, 1'b0, 8'hFB, 3'd4, 1'b0, 1};
    vecs[4]  = '{3'd0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1};
    vecs[5]  = '{3'd5, 8'h55, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 3'd0, 1'b0, 0};
    vecs[6]  = '{3'd0, 8'h01, 8'h00, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 8'h02, 3'd0, 1'b1, 1};
    vecs[7]  = '{3'd1, 8'h00, 8'h01, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 8'hFF, 3'd1, 1'b0, 1};
    vecs[8]  = '{3'd1, 8'h00, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 8'hFF, 3'd1, 1'b1, 1};
    vecs[9]  = '{3'd7, 8'h12, 8'h34, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'hFF, 3'd1, 1'b1, 0};
    vecs[10] = '{3'd3, 8'hF0, 8'h0F, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF, 3'd3, 1'b0, 1};
    vecs[11] = '{3'd0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1};

    rst = 1'b1; rst_4 = 1'b1;
    cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0; cmd_use_acc = 0; cmd_use_carry = 0;
    rsp_ready = 0;
    cmd_valid_4 = 0; cmd_op_4 = 0; cmd_a_4 = 0; cmd_b_4 = 0; cmd_use_acc_4 = 0;
    cmd_use_carry_4 = 0; rsp_ready_4 = 0;
    repeat (2) @(negedge clk);

    check("reset_cmd_ready", int'(cmd_ready), 1);
    check("reset_rsp_valid", int'(rsp_valid), 0);
    check("reset_acc", int'(acc), 0);
    check("reset_ula_drive", int'({ula_a, ula_b, ula_x, ula_cin}), 0);
    check("reset_rsp_fields", int'({rsp_data, rsp_cout, rsp_zero, rsp_err}), 0);
    rst = 1'b0; rst_4 = 1'b0;
    @(negedge clk);

    // ---- reset during ISSUE on the SETTLE_CYCLES=4 instance ----
    cmd_valid_4 = 1'b1; cmd_op_4 = 3'd0; cmd_a_4 = 8'h10; cmd_b_4 = 8'h20;
    @(posedge clk);
    @(negedge clk);
    cmd_valid_4 = 1'b0;
    check("s4_busy_in_issue", int'(cmd_ready_4), 0);
    check("s4_ula_a_loaded", int'(ula_a_4), 'h10);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_4 = 1'b1;
    #1;
    check("s4_rst_cmd_ready", int'(cmd_ready_4), 1);
    check("s4_rst_rsp_valid", int'(rsp_valid_4), 0);
    check("s4_rst_outputs",
          int'({acc_4, ula_a_4, ula_b_4, ula_x_4, ula_cin_4, rsp_data_4, rsp_cout_4, rsp_zero_4, rsp_err_4}), 0);
    @(negedge clk);
    rst_4 = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid_4) seen = 1'b1;
    end
    check("s4_no_stale_rsp", int'(seen), 0);
    cmd_valid_4 = 1'b1; cmd_op_4 = 3'd0; cmd_a_4 = 8'h05; cmd_b_4 = 8'h07;
    @(posedge clk);
    @(negedge clk);
    cmd_valid_4 = 1'b0;
    lat = 0;
    while (!rsp_valid_4 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("s4_latency", lat, 4);
    check("s4_data", int'(rsp_data_4), 'h0C);
    rsp_ready_4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready_4 = 1'b0;
    check("s4_back_idle", int'(cmd_ready_4), 1);

    // ---- directed table ----
    for (int i = 0; i < NV; i++) begin
      send_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ua, vecs[i].uc);
      wait_rsp(lat);
      check($sformatf("v%0d_lat", i), lat, vecs[i].e_lat);
      check($sformatf("v%0d_data", i), int'(rsp_data), int'(vecs[i].e_data));
      check($sformatf("v%0d_cout", i), int'(rsp_cout), int'(vecs[i].e_cout));
      check($sformatf("v%0d_zero", i), int'(rsp_zero), int'(vecs[i].e_zero));
      check($sformatf("v%0d_err", i), int'(rsp_err), int'(vecs[i].e_err));
      check($sformatf("v%0d_acc", i), int'(acc), int'(vecs[i].e_acc));
      check($sformatf("v%0d_ula_x", i), int'(ula_x), int'(vecs[i].e_x));
      check($sformatf("v%0d_ula_cin", i), int'(ula_cin), int'(vecs[i].e_cin));
      finish_rsp();
    end

    // ---- backpressure, with an ignored command pulse ----
    send_cmd(3'd0, 8'h12, 8'h34, 1'b0, 1'b0);
    wait_rsp(lat);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_valid", i), int'(rsp_valid), 1);
      check($sformatf("bp%0d_data", i), int'(rsp_data), 'h46);
      check($sformatf("bp%0d_cmd_ready", i), int'(cmd_ready), 0);
      cmd_valid = (i == 1);
      cmd_op = 3'd0; cmd_a = 8'hAA; cmd_b = 8'h11;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    finish_rsp();
    check("bp_idle_ready", int'(cmd_ready), 1);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("bp_pulse_ignored", int'(seen), 0);
    check("bp_acc", int'(acc), 'h46);

    // ---- randomized against reference model ----
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rand_reset_acc", int'(acc), 0);
    m_acc = 8'h00;
    m_carry = 1'b0;
    for (int n = 0; n < 150; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = 8'($urandom);
      ua = 1'($urandom);
      uc = 1'($urandom);
      a_eff  = ua ? m_acc : a;
      cin    = uc ? m_carry : 1'b0;
      e_err  = 1'b0;
      e_cout = 1'b0;
      e_data = 8'h00;
      case (op)
        3'd0: begin
          t = int'(a_eff) + int'(b) + int'(cin);
          e_data = t[7:0];
          e_cout = (t > 255);
        end
        3'd1: begin
          t = int'(a_eff) - int'(b) - int'(cin);
          e_data = t[7:0];
          e_cout = (t < 0);
        end
        3'd2: e_data = a_eff & b;
        3'd3: e_data = a_eff | b;
        3'd4: e_data = ~a_eff;
        default: e_err = 1'b1;
      endcase
      if (!e_err) begin
        m_acc   = e_data;
        m_carry = e_cout;
      end
      send_cmd(op, a, b, ua, uc);
      wait_rsp(lat);
      check($sformatf("r%0d_lat", n), lat, e_err ? 0 : 1);
      check($sformatf("r%0d_data", n), int'(rsp_data), int'(e_data));
      check($sformatf("r%0d_cout", n), int'(rsp_cout), int'(e_cout));
      check($sformatf("r%0d_zero", n), int'(rsp_zero), int'(e_data == 8'h00));
      check($sformatf("r%0d_err", n), int'(rsp_err), int'(e_err));
      check($sformatf("r%0d_acc", n), int'(acc), int'(m_acc));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      finish_rsp();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
